snake_engine: RTL and testbench

//  Parametrised snake game core: grid size, max length and start length are parameters.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_engine_if.sv | 39 +++
 rtl/snake_ring.sv | 56 +++++
 rtl/snake_engine.sv | 198 +++++++++++++++++++
 tb/tb_snake_engine.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game core: directions, PS/2 arrow key codes,
// FSM state encodings and the direction-reversal helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  // up<->down and left<->right differ only in bit 0
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Control/query bundle between game_state/ps2/VGA logic (master) and the
// snake engine (slave).
interface snake_engine_if #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int MAX_LEN = 256
);
  import snake_pkg::*;

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int L_W = $clog2(MAX_LEN + 1);

  logic           init;
  logic           step;
  logic [1:0]     dir;
  logic [X_W-1:0] apple_x;
  logic [Y_W-1:0] apple_y;
  logic [X_W-1:0] cell_x;
  logic [Y_W-1:0] cell_y;
  logic           cell_occ;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [L_W-1:0] length;
  logic           busy;
  logic           ate;
  logic           died;

  modport master (
    output init, step, dir, apple_x, apple_y, cell_x, cell_y,
    input  cell_occ, head_x, head_y, length, busy, ate, died
  );

  modport slave (
    input  init, step, dir, apple_x, apple_y, cell_x, cell_y,
    output cell_occ, head_x, head_y, length, busy, ate, died
  );

endinterface

// File: rtl/snake_ring.sv
// Body position store: ring buffer of {y,x} cells with head/tail pointers,
// one head write port and a registered tail read.
module snake_ring
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 256,
  parameter int INIT_LEN = 4,
  parameter int X_W      = 6,
  parameter int Y_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             wr_en,
  input  logic             adv,
  input  logic [X_W+Y_W-1:0] wr_pos,
  output logic [X_W+Y_W-1:0] tail_pos
);

  localparam int POS_W = X_W + Y_W;
  localparam int P_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [POS_W-1:0] mem [MAX_LEN];
  logic [P_W-1:0]   head_ptr;
  logic [P_W-1:0]   tail_ptr;

  function automatic logic [P_W-1:0] next_ptr(input logic [P_W-1:0] p);
    return (p == P_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  // Initial body occupies slots 0..INIT_LEN-1 holding cells (i,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= P_W'(INIT_LEN - 1);
      tail_ptr <= '0;
      tail_pos <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++)
        mem[i] <= (i < INIT_LEN) ? {Y_W'(0), X_W'(i)} : '0;
    end else if (init) begin
      head_ptr <= P_W'(INIT_LEN - 1);
      tail_ptr <= '0;
      tail_pos <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++)
        mem[i] <= (i < INIT_LEN) ? {Y_W'(0), X_W'(i)} : '0;
    end else begin
      tail_pos <= mem[tail_ptr];
      if (wr_en) begin
        mem[next_ptr(head_ptr)] <= wr_pos;
        head_ptr <= next_ptr(head_ptr);
      end
      if (adv)
        tail_ptr <= next_ptr(tail_ptr);
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: FSM, occupancy map and registered cell query port.
// Optional SNAKE_WRAP_EN: head wraps at the grid edges instead of dying.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MAX_LEN  = 256,
  parameter int INIT_LEN = 4
) (
  input logic          clk,
  input logic          rst,
  snake_engine_if.slave bus
);

  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int L_W   = $clog2(MAX_LEN + 1);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int M_W   = $clog2(CELLS);

  function automatic logic [CELLS-1:0] init_map();
    logic [CELLS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < INIT_LEN; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [CELLS-1:0] INIT_MAP = init_map();

  function automatic logic [M_W-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return M_W'(y) * M_W'(GRID_W) + M_W'(x);
  endfunction

  logic [1:0]       state;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [1:0]       last_dir;
  logic [L_W-1:0]   length;
  logic             busy;
  logic             ate;
  logic             died;
  logic             cell_occ;
  logic [CELLS-1:0] map;

  logic [X_W-1:0]   nxt_x_q;
  logic [Y_W-1:0]   nxt_y_q;
  logic             eat_q;
  logic [1:0]       dir_q;

  logic [1:0]       acc_dir;
  logic [X_W-1:0]   nxt_x;
  logic [Y_W-1:0]   nxt_y;
  logic             at_edge;
  logic             oob;
  logic             eat;
  logic             hit;
  logic [X_W+Y_W-1:0] tail_pos;
  logic [X_W-1:0]   tail_x;
  logic [Y_W-1:0]   tail_y;
  logic             full;
  logic             vacate;
  logic             in_range;

  assign tail_x = tail_pos[X_W-1:0];
  assign tail_y = tail_pos[X_W +: Y_W];
  assign acc_dir = (bus.dir == opposite(last_dir)) ? last_dir : bus.dir;
  assign full    = (length == L_W'(MAX_LEN));
  assign vacate  = !eat_q || full;

  // Next head cell; the edge case always yields the wrapped coordinate
  always_comb begin
    nxt_x   = head_x;
    nxt_y   = head_y;
    at_edge = 1'b0;
    case (acc_dir)
      DIR_UP: begin
        if (head_y == '0) begin at_edge = 1'b1; nxt_y = Y_W'(GRID_H - 1); end
        else nxt_y = head_y - 1'b1;
      end
      DIR_DOWN: begin
        if (head_y == Y_W'(GRID_H - 1)) begin at_edge = 1'b1; nxt_y = '0; end
        else nxt_y = head_y + 1'b1;
      end
      DIR_LEFT: begin
        if (head_x == '0) begin at_edge = 1'b1; nxt_x = X_W'(GRID_W - 1); end
        else nxt_x = head_x - 1'b1;
      end
      default: begin
        if (head_x == X_W'(GRID_W - 1)) begin at_edge = 1'b1; nxt_x = '0; end
        else nxt_x = head_x + 1'b1;
      end
    endcase
`ifdef SNAKE_WRAP_EN
    oob = 1'b0;
`else
    oob = at_edge;
`endif
  end

  assign eat = (nxt_x == bus.apple_x) && (nxt_y == bus.apple_y);
  assign hit = oob || (map[cell_idx(nxt_x, nxt_y)] &&
               !((nxt_x == tail_x) && (nxt_y == tail_y) && !eat));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      head_x   <= X_W'(INIT_LEN - 1);
      head_y   <= '0;
      last_dir <= DIR_RIGHT;
      length   <= L_W'(INIT_LEN);
      busy     <= 1'b0;
      ate      <= 1'b0;
      died     <= 1'b0;
      map      <= INIT_MAP;
      nxt_x_q  <= '0;
      nxt_y_q  <= '0;
      eat_q    <= 1'b0;
      dir_q    <= DIR_RIGHT;
    end else if (bus.init) begin
      state    <= ST_IDLE;
      head_x   <= X_W'(INIT_LEN - 1);
      head_y   <= '0;
      last_dir <= DIR_RIGHT;
      length   <= L_W'(INIT_LEN);
      busy     <= 1'b0;
      ate      <= 1'b0;
      died     <= 1'b0;
      map      <= INIT_MAP;
      nxt_x_q  <= '0;
      nxt_y_q  <= '0;
      eat_q    <= 1'b0;
      dir_q    <= DIR_RIGHT;
    end else begin
      ate  <= 1'b0;
      busy <= (state == ST_CHECK) || (state == ST_COMMIT);
      case (state)
        ST_IDLE:
          if (bus.step) state <= ST_CHECK;
        ST_CHECK: begin
          nxt_x_q <= nxt_x;
          nxt_y_q <= nxt_y;
          eat_q   <= eat;
          dir_q   <= acc_dir;
          state   <= hit ? ST_DEAD : ST_COMMIT;
        end
        ST_COMMIT: begin
          head_x   <= nxt_x_q;
          head_y   <= nxt_y_q;
          last_dir <= dir_q;
          // clear-then-set ordering lets the new head win over the vacated tail
          if (vacate) map[cell_idx(tail_x, tail_y)] <= 1'b0;
          map[cell_idx(nxt_x_q, nxt_y_q)] <= 1'b1;
          if (eat_q && !full) length <= length + 1'b1;
          ate   <= eat_q;
          state <= ST_IDLE;
        end
        default:
          died <= 1'b1;
      endcase
    end
  end

  assign in_range = (32'(bus.cell_x) < GRID_W) && (32'(bus.cell_y) < GRID_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cell_occ <= 1'b0;
    else if (bus.init)
      cell_occ <= 1'b0;
    else
      cell_occ <= in_range && map[in_range ? cell_idx(bus.cell_x, bus.cell_y) : '0];
  end

  snake_ring #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .init     (bus.init),
    .wr_en    (state == ST_COMMIT),
    .adv      ((state == ST_COMMIT) && vacate),
    .wr_pos   ({nxt_y_q, nxt_x_q}),
    .tail_pos (tail_pos)
  );

  assign bus.head_x   = head_x;
  assign bus.head_y   = head_y;
  assign bus.length   = length;
  assign bus.busy     = busy;
  assign bus.ate      = ate;
  assign bus.died     = died;
  assign bus.cell_occ = cell_occ;

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a queue-based body model predicts each
// move; a monitor compares when busy falls, on snapshots and on cell queries.
module tb_snake_engine;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int ML = 8;
  localparam int IL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_engine_if #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML)) bus ();

  snake_engine #(
    .GRID_W   (W),
    .GRID_H   (H),
    .MAX_LEN  (ML),
    .INIT_LEN (IL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int hx; int hy; int len; int ate; int died; } exp_t;
  exp_t exp_q[$];
  int   occ_q[$];

  int tests = 0;
  int fails = 0;

  int body[$];
  int last_dir;
  bit dead;
  int opp_tab[4] = '{1, 0, 3, 2};

  logic snap = 1'b0;
  logic qv = 1'b0;
  logic qv_d = 1'b0;
  logic busy_prev = 1'b0;
  int   ate_seen = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    body.delete();
    for (int i = 0; i < IL; i++) body.push_back(i);
    last_dir = 3;
    dead = 1'b0;
  endfunction

  function automatic int model_occ(input int x, input int y);
    if (x >= W || y >= H) return 0;
    foreach (body[k]) if (body[k] == y * W + x) return 1;
    return 0;
  endfunction

  function automatic void push_exp(input int ate_n);
    exp_t e;
    e.hx = body[body.size()-1] % W;
    e.hy = body[body.size()-1] / W;
    e.len = body.size();
    e.ate = ate_n;
    e.died = dead;
    exp_q.push_back(e);
  endfunction

  // Returns 1 when the DUT is expected to perform (and report) a move
  function automatic bit model_step(input int d, input int ax, input int ay);
    int acc, nx, ny, c;
    bit oob, eat, hit;
    if (dead) return 1'b0;
    acc = (d == opp_tab[last_dir]) ? last_dir : d;
    nx = body[body.size()-1] % W;
    ny = body[body.size()-1] / W;
    case (acc)
      0: ny--;
      1: ny++;
      2: nx--;
      default: nx++;
    endcase
    oob = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
`ifdef SNAKE_WRAP_EN
    nx = (nx + W) % W;
    ny = (ny + H) % H;
    oob = 1'b0;
`endif
    eat = (nx == ax) && (ny == ay);
    hit = oob;
    c = ny * W + nx;
    if (!oob)
      foreach (body[k]) if (body[k] == c && !(k == 0 && !eat)) hit = 1'b1;
    if (hit) begin
      dead = 1'b1;
      push_exp(0);
    end else begin
      body.push_back(c);
      if (!eat || body.size() > ML) void'(body.pop_front());
      last_dir = acc;
      push_exp(eat ? 1 : 0);
    end
    return 1'b1;
  endfunction

  always @(posedge clk) qv_d <= qv;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ate) ate_seen++;
      if ((busy_prev && !bus.busy) || snap) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: actual 0 entries required 1");
        end else begin
          mon_e = exp_q.pop_front();
          chk("head_x", 32'(bus.head_x), mon_e.hx);
          chk("head_y", 32'(bus.head_y), mon_e.hy);
          chk("length", 32'(bus.length), mon_e.len);
          chk("died", 32'(bus.died), mon_e.died);
          chk("ate_pulses", ate_seen, mon_e.ate);
          if (snap) chk("busy_idle", 32'(bus.busy), 0);
        end
        ate_seen = 0;
      end
      busy_prev = bus.busy;
      if (qv_d) begin
        if (occ_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL occ_queue_empty: actual 0 entries required 1");
        end else begin
          chk("cell_occ", 32'(bus.cell_occ), occ_q.pop_front());
        end
      end
    end
  end

  task automatic do_step(input int d, input int ax, input int ay, input bit hold = 1'b0);
    bus.dir = 2'(d);
    bus.apple_x = 6'(ax);
    bus.apple_y = 6'(ay);
    bus.step = 1'b1;
    void'(model_step(d, ax, ay));
    @(posedge clk); #1;
    if (hold) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    bus.step = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic snapshot();
    push_exp(0);
    snap = 1'b1;
    @(posedge clk); #1;
    snap = 1'b0;
  endtask

  task automatic query(input int x, input int y);
    bus.cell_x = 6'(x);
    bus.cell_y = 6'(y);
    occ_q.push_back(model_occ(x, y));
    qv = 1'b1;
    @(posedge clk); #1;
    qv = 1'b0;
  endtask

  task automatic do_init();
    bus.init = 1'b1;
    model_reset();
    @(posedge clk); #1;
    bus.init = 1'b0;
    snapshot();
  endtask

  initial begin
    int hx, hy, d, ax, ay, c;
    bus.init = 1'b0; bus.step = 1'b0; bus.dir = 2'd3;
    bus.apple_x = 6'd40; bus.apple_y = 6'd40;
    bus.cell_x = '0; bus.cell_y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cell_occ", 32'(bus.cell_occ), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ate", 32'(bus.ate), 0);
    rst = 1'b0;
    snapshot();

    // three moves right, then occupancy around the tail
    repeat (3) do_step(3, 40, 40);
    snapshot();
    query(2, 0); query(3, 0); query(6, 0); query(10, 50);
    // eat directly ahead; old tail stays
    do_step(3, 7, 0);
    query(3, 0);
    // reversal request is replaced by the current direction
    do_step(2, 40, 40);
    // run to the right edge and beyond
    while (!dead && (body[body.size()-1] % W) != W - 1) do_step(3, 40, 40);
    do_step(3, 40, 40);
    do_step(1, 40, 40);
    do_step(1, 40, 40);
    snapshot();
    do_init();
    query(0, 0); query(3, 0); query(4, 0);

    // length 4: entering the vacating tail cell survives
    do_step(1, 40, 40); do_step(2, 40, 40); do_step(0, 40, 40);
    do_init();
    // length 5: the same loop bites the body
    do_step(3, 4, 0);
    do_step(1, 40, 40); do_step(2, 40, 40); do_step(0, 40, 40);
    snapshot();
    do_init();

    // step held through the busy window counts once
    do_step(1, 40, 40, 1'b1);
    // init while the move is in CHECK aborts it
    bus.dir = 2'd1;
    bus.step = 1'b1;
    @(posedge clk); #1;
    bus.step = 1'b0;
    bus.init = 1'b1;
    model_reset();
    @(posedge clk); #1;
    bus.init = 1'b0;
    snapshot();
    query(3, 1); query(3, 0);

    // randomized episodes
    for (int ep = 0; ep < 12; ep++) begin
      do_init();
      for (int s = 0; s < 30 && !dead; s++) begin
        d = $urandom_range(0, 3);
        hx = body[body.size()-1] % W;
        hy = body[body.size()-1] / W;
        ax = $urandom_range(0, W - 1);
        ay = $urandom_range(0, H - 1);
        if ($urandom_range(0, 1) == 1) begin
          ax = hx + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
          ay = hy + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
          if (ax < 0 || ax >= W || ay < 0 || ay >= H) begin ax = 0; ay = H - 1; end
        end
        do_step(d, ax, ay);
        c = body[$urandom_range(0, body.size() - 1)];
        query(c % W, c / W);
        query($urandom_range(0, 63), $urandom_range(0, 63));
      end
      if (dead) begin
        do_step($urandom_range(0, 3), 40, 40);
        snapshot();
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("occ_queue_drained", occ_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
